// File: rtl/common_types_pkg.sv
// ---------------------------------------------------------------------------
// common_types_pkg -- CSR addresses, cause codes and FSM state shared by the
// trap controller.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package common_types_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [31:0] CAUSE_ILLEGAL_INST     = 32'd2;
  localparam logic [31:0] CAUSE_BREAKPOINT       = 32'd3;
  localparam logic [31:0] CAUSE_LOAD_MISALIGNED  = 32'd4;
  localparam logic [31:0] CAUSE_STORE_MISALIGNED = 32'd6;
  localparam logic [31:0] CAUSE_ECALL_M          = 32'd11;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  localparam int IRQ_IDX_W = 4;
  localparam logic [30:0] IRQ_CAUSE_BASE = 31'd16;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } trap_state_e;

  // External line i reports cause {interrupt, 16+i}.
  function automatic logic [31:0] irq_cause(input logic [IRQ_IDX_W-1:0] idx);
    return {1'b1, IRQ_CAUSE_BASE + {27'd0, idx}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/trap_priority.sv
// ---------------------------------------------------------------------------
// trap_priority -- fixed-priority encoder, lowest pending index wins.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module trap_priority
  import common_types_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0]   pending,
  output logic                 valid,
  output logic [IRQ_IDX_W-1:0] index
);

  always_comb begin
    valid = |pending;
    index = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) index = IRQ_IDX_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/trap_controller.sv
// ---------------------------------------------------------------------------
// trap_controller -- machine-mode trap/MRET sequencing and trap CSRs.
// Optional vectored interrupts: define TRAP_VECTORED_IRQ_EN.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module trap_controller
  import common_types_pkg::*;
#(
  parameter int          NUM_IRQ    = 4,
  parameter logic [31:0] RESET_TVEC = 32'h8000
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               illegal_inst,
  input  logic               ecall,
  input  logic               ebreak,
  input  logic               load_misaligned,
  input  logic               store_misaligned,
  input  logic               mem_valid,
  input  logic [31:0]        mem_pc,
  input  logic [31:0]        mem_tval,
  input  logic               mret,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               csr_en,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  output logic               redirect,
  output logic [31:0]        redirect_pc,
  output logic               f2dif_flush,
  output logic               d2eif_flush,
  output logic               e2mif_flush,
  output logic               m2wif_flush,
  output logic [31:0]        trap_cause
);

  trap_state_e          state;
  logic                 mstatus_mie;
  logic                 mstatus_mpie;
  logic [NUM_IRQ-1:0]   mie_q;
  logic [NUM_IRQ-1:0]   mip_q;
  logic [31:0]          mepc_q;
  logic [31:0]          mcause_q;
  logic [31:0]          mtval_q;
  logic [31:2]          tvec_base;
  logic [31:0]          mtvec_val;

  logic                 fault_any;
  logic [31:0]          fault_cause;
  logic                 irq_valid;
  logic [IRQ_IDX_W-1:0] irq_idx;
  logic [31:0]          cause;
  logic [31:0]          trap_target;
  logic                 in_run;
  logic                 trap_take;
  logic                 mret_take;
  logic                 flush_all;

`ifdef TRAP_VECTORED_IRQ_EN
  logic [1:0] tvec_mode;
  assign mtvec_val = {tvec_base, tvec_mode};
`else
  assign mtvec_val = {tvec_base, 2'b00};
`endif

  trap_priority #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio (
    .pending (mip_q & mie_q),
    .valid   (irq_valid),
    .index   (irq_idx)
  );

  assign fault_any = illegal_inst | ecall | ebreak | load_misaligned | store_misaligned;

  always_comb begin
    if (ebreak)                fault_cause = CAUSE_BREAKPOINT;
    else if (illegal_inst)     fault_cause = CAUSE_ILLEGAL_INST;
    else if (ecall)            fault_cause = CAUSE_ECALL_M;
    else if (load_misaligned)  fault_cause = CAUSE_LOAD_MISALIGNED;
    else                       fault_cause = CAUSE_STORE_MISALIGNED;
  end

  assign cause = fault_any ? fault_cause : irq_cause(irq_idx);

  // Vector offset is 4*cause[30:0]; the shift discards the interrupt flag.
  always_comb begin
    trap_target = {tvec_base, 2'b00};
`ifdef TRAP_VECTORED_IRQ_EN
    if (!fault_any && tvec_mode == 2'b01)
      trap_target = {tvec_base, 2'b00} + (cause << 2);
`endif
  end

  // Gating with nrst keeps every output idle while reset is held.
  assign in_run    = nrst && (state == ST_RUN);
  assign trap_take = in_run && mem_valid && (fault_any || (mstatus_mie && irq_valid));
  assign mret_take = in_run && mem_valid && mret && !trap_take;
  assign flush_all = trap_take || mret_take || (nrst && (state == ST_DRAIN));

  assign redirect    = trap_take || mret_take;
  assign redirect_pc = trap_take ? trap_target : (mret_take ? mepc_q : 32'd0);
  assign trap_cause  = trap_take ? cause : 32'd0;
  assign f2dif_flush = flush_all;
  assign d2eif_flush = flush_all;
  assign e2mif_flush = flush_all;
  assign m2wif_flush = flush_all;

  always_comb begin
    csr_rdata = 32'd0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MIE_BIT]  = mstatus_mie;
        csr_rdata[MSTATUS_MPIE_BIT] = mstatus_mpie;
      end
      CSR_MIE:    csr_rdata = 32'(mie_q);
      CSR_MTVEC:  csr_rdata = mtvec_val;
      CSR_MEPC:   csr_rdata = mepc_q;
      CSR_MCAUSE: csr_rdata = mcause_q;
      CSR_MTVAL:  csr_rdata = mtval_q;
      CSR_MIP:    csr_rdata = 32'(mip_q);
      default:    csr_rdata = 32'd0;
    endcase
  end

  // CSR writes come first so trap/MRET updates later in the block win.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= ST_RUN;
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      mip_q        <= '0;
      mepc_q       <= 32'd0;
      mcause_q     <= 32'd0;
      mtval_q      <= 32'd0;
      tvec_base    <= RESET_TVEC[31:2];
`ifdef TRAP_VECTORED_IRQ_EN
      tvec_mode    <= RESET_TVEC[1:0];
`endif
    end else begin
      mip_q <= irq;

      if (csr_en) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mstatus_mie  <= csr_wdata[MSTATUS_MIE_BIT];
            mstatus_mpie <= csr_wdata[MSTATUS_MPIE_BIT];
          end
          CSR_MIE:    mie_q <= csr_wdata[NUM_IRQ-1:0];
          CSR_MTVEC: begin
            tvec_base <= csr_wdata[31:2];
`ifdef TRAP_VECTORED_IRQ_EN
            tvec_mode <= csr_wdata[1:0];
`endif
          end
          CSR_MEPC:   mepc_q   <= csr_wdata & 32'hFFFF_FFFC;
          CSR_MCAUSE: mcause_q <= csr_wdata;
          CSR_MTVAL:  mtval_q  <= csr_wdata;
          default: ;
        endcase
      end

      if (state == ST_DRAIN) begin
        state <= ST_RUN;
      end else if (trap_take) begin
        state        <= ST_DRAIN;
        mepc_q       <= mem_pc & 32'hFFFF_FFFC;
        mcause_q     <= cause;
        mtval_q      <= fault_any ? mem_tval : 32'd0;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (mret_take) begin
        state        <= ST_DRAIN;
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_trap_controller.sv
// ---------------------------------------------------------------------------
// tb_trap_controller -- directed self-checking bench for trap_controller.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_trap_controller;
  import common_types_pkg::*;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        illegal_inst, ecall, ebreak, load_misaligned, store_misaligned;
  logic        mem_valid, mret;
  logic [31:0] mem_pc, mem_tval;
  logic [3:0]  irq;
  logic        csr_en;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        redirect;
  logic [31:0] redirect_pc, trap_cause;
  logic        f2dif_flush, d2eif_flush, e2mif_flush, m2wif_flush;
  logic [3:0]  flushes;

  int passed = 0;
  int total  = 0;

  assign flushes = {f2dif_flush, d2eif_flush, e2mif_flush, m2wif_flush};

  trap_controller #(
    .NUM_IRQ    (4),
    .RESET_TVEC (32'h8000)
  ) dut (
    .clk              (clk),
    .nrst             (nrst),
    .illegal_inst     (illegal_inst),
    .ecall            (ecall),
    .ebreak           (ebreak),
    .load_misaligned  (load_misaligned),
    .store_misaligned (store_misaligned),
    .mem_valid        (mem_valid),
    .mem_pc           (mem_pc),
    .mem_tval         (mem_tval),
    .mret             (mret),
    .irq              (irq),
    .csr_en           (csr_en),
    .csr_addr         (csr_addr),
    .csr_wdata        (csr_wdata),
    .csr_rdata        (csr_rdata),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .f2dif_flush      (f2dif_flush),
    .d2eif_flush      (d2eif_flush),
    .e2mif_flush      (e2mif_flush),
    .m2wif_flush      (m2wif_flush),
    .trap_cause       (trap_cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    illegal_inst = 1'b0; ecall = 1'b0; ebreak = 1'b0;
    load_misaligned = 1'b0; store_misaligned = 1'b0;
    mem_valid = 1'b0; mret = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr = addr;
    #1;
    check(tag, csr_rdata, exp);
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    csr_en = 1'b1; csr_addr = addr; csr_wdata = data;
    step();
    csr_en = 1'b0;
  endtask

  // One fault instruction: same-cycle cause, then mcause after the edge.
  task automatic fault(input string tag, input logic [4:0] f, input logic [31:0] exp);
    mem_valid = 1'b1;
    {ebreak, illegal_inst, ecall, load_misaligned, store_misaligned} = f;
    #1;
    check({tag, "_cause"}, trap_cause, exp);
    step();
    clr();
    rd({tag, "_mcause"}, CSR_MCAUSE, exp);
    step();
  endtask

  initial begin
    clr();
    irq = 4'h0; csr_en = 1'b0; csr_addr = 12'h0; csr_wdata = 32'h0;
    mem_pc = 32'h0; mem_tval = 32'h0;

    // Reset: outputs idle even with a fault presented
    repeat (2) @(posedge clk);
    #1;
    mem_valid = 1'b1; illegal_inst = 1'b1;
    #1;
    check("rst_redirect", 32'(redirect), 32'd0);
    check("rst_flush", 32'(flushes), 32'd0);
    check("rst_cause", trap_cause, 32'd0);
    clr();
    rd("rst_mtvec", CSR_MTVEC, 32'h8000);
    rd("rst_mstatus", CSR_MSTATUS, 32'h0);
    rd("rst_mepc", CSR_MEPC, 32'h0);
    nrst = 1'b1;
    step();

    // Illegal instruction trap and drain
    mem_valid = 1'b1; illegal_inst = 1'b1; mem_pc = 32'h120; mem_tval = 32'hFFFF_FFFF;
    #1;
    check("ill_redirect", 32'(redirect), 32'd1);
    check("ill_pc", redirect_pc, 32'h8000);
    check("ill_flush", 32'(flushes), 32'hF);
    check("ill_cause", trap_cause, 32'd2);
    step();
    check("drain_redirect", 32'(redirect), 32'd0);
    check("drain_cause", trap_cause, 32'd0);
    check("drain_flush", 32'(flushes), 32'hF);
    clr();
    rd("ill_mepc", CSR_MEPC, 32'h120);
    rd("ill_mcause", CSR_MCAUSE, 32'd2);
    rd("ill_mtval", CSR_MTVAL, 32'hFFFF_FFFF);
    step();
    check("run_flush", 32'(flushes), 32'd0);

    // Fault priority (ebreak, illegal, ecall, load, store)
    fault("pri_eb_ill_ec", 5'b11100, 32'd3);
    fault("pri_ec_ld_st", 5'b00111, 32'd11);
    fault("pri_ld_st", 5'b00011, 32'd4);
    fault("pri_st", 5'b00001, 32'd6);
    fault("pri_ill_ld", 5'b01010, 32'd2);

    // Coincident mepc write loses to the trap
    mem_valid = 1'b1; store_misaligned = 1'b1; mem_pc = 32'h300;
    wr(CSR_MEPC, 32'h999);
    clr();
    rd("coinc_mepc", CSR_MEPC, 32'h300);
    step();

    // Unmapped and read-only CSRs
    wr(12'h123, 32'hDEAD_BEEF);
    rd("unmapped", 12'h123, 32'h0);
    wr(CSR_MIP, 32'hF);
    rd("mip_ro", CSR_MIP, 32'h0);

    // Interrupt trap
    wr(CSR_MIE, 32'h3);
    wr(CSR_MSTATUS, 32'hFFFF_FFFF);
    rd("mstatus_mask", CSR_MSTATUS, 32'h88);
    wr(CSR_MSTATUS, 32'h8);
    irq = 4'h3; mem_valid = 1'b1; mem_pc = 32'h400; mem_tval = 32'h77;
    #1;
    check("irq_latency", 32'(redirect), 32'd0);
    step();
    check("irq_redirect", 32'(redirect), 32'd1);
    check("irq_cause", trap_cause, 32'h8000_0010);
    check("irq_pc", redirect_pc, 32'h8000);
    step();
    rd("irq_mcause", CSR_MCAUSE, 32'h8000_0010);
    rd("irq_mtval", CSR_MTVAL, 32'h0);
    rd("irq_mstatus", CSR_MSTATUS, 32'h80);
    rd("irq_mepc", CSR_MEPC, 32'h400);
    step();
    check("irq_no_retrap", 32'(redirect), 32'd0);
    rd("irq_mip", CSR_MIP, 32'h3);

    // MRET
    mem_valid = 1'b0;
    wr(CSR_MEPC, 32'h127);
    rd("mepc_align", CSR_MEPC, 32'h124);
    mem_valid = 1'b1; mret = 1'b1;
    #1;
    check("mret_redirect", 32'(redirect), 32'd1);
    check("mret_pc", redirect_pc, 32'h124);
    check("mret_flush", 32'(flushes), 32'hF);
    check("mret_cause", trap_cause, 32'h0);
    step();
    clr();
    irq = 4'h0;
    rd("mret_mstatus", CSR_MSTATUS, 32'h88);
    step();
    check("mret_run", 32'(flushes), 32'd0);

    // Vectored / direct mode
    wr(CSR_MTVEC, 32'h8001);
`ifdef TRAP_VECTORED_IRQ_EN
    rd("mtvec_rd", CSR_MTVEC, 32'h8001);
`else
    rd("mtvec_rd", CSR_MTVEC, 32'h8000);
`endif
    wr(CSR_MIE, 32'h4);
    irq = 4'h4;
    step();
    mem_valid = 1'b1;
    #1;
    check("vec_cause", trap_cause, 32'h8000_0012);
`ifdef TRAP_VECTORED_IRQ_EN
    check("vec_pc", redirect_pc, 32'h8048);
`else
    check("vec_pc", redirect_pc, 32'h8000);
`endif
    step();
    clr();
    irq = 4'h0;
    step();
    mem_valid = 1'b1; ecall = 1'b1;
    #1;
    check("vec_fault_pc", redirect_pc, 32'h8000);
    step();
    clr();
    step();

    // Reset during drain
    mem_valid = 1'b1; load_misaligned = 1'b1; mem_tval = 32'h1234;
    step();
    clr();
    check("rd_drain_flush", 32'(flushes), 32'hF);
    nrst = 1'b0;
    #1;
    check("rd_flush", 32'(flushes), 32'd0);
    rd("rd_mepc", CSR_MEPC, 32'h0);
    rd("rd_mtvec", CSR_MTVEC, 32'h8000);
    rd("rd_mstatus", CSR_MSTATUS, 32'h0);
    rd("rd_mcause", CSR_MCAUSE, 32'h0);
    step();
    nrst = 1'b1;
    step();
    check("rd_release_flush", 32'(flushes), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/trap_controller.md
TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 Parameter NUM_IRQ, 4, number of external interrupt lines (1..16).
REQ-002 Parameter RESET_TVEC, 32'h8000, reset value of mtvec base.
REQ-003 Port clk  in  1  sole clock; all state changes on rising edge.
REQ-004 Port nrst  in  1  reset; asynchronous, active-low.
REQ-005 Ports illegal_inst, ecall, ebreak, load_misaligned, store_misaligned  in  1 each  synchronous fault flags for the memory-stage instruction.
REQ-006 Ports mem_valid  in  1, mem_pc  in  32, mem_tval  in  32  memory-stage instruction valid, PC, fault value (bad address/instruction).
REQ-007 Port mret  in  1  memory-stage instruction is MRET.
REQ-008 Port irq  in  NUM_IRQ  level-sensitive interrupt requests, already synchronous to clk.
REQ-009 Ports csr_en  in  1, csr_addr  in  12, csr_wdata  in  32, csr_rdata  out  32  CSR access port; write when csr_en=1, combinational read.
REQ-010 Ports redirect  out  1, redirect_pc  out  32  fetch redirect strobe and target.
REQ-011 Ports f2dif_flush, d2eif_flush, e2mif_flush, m2wif_flush  out  1 each  pipeline register flushes.
REQ-012 Port trap_cause  out  32  cause of the trap taken this cycle, 0 otherwise.

Function
REQ-013 FSM states RUN, DRAIN; reset state RUN.
REQ-014 RUN: trap taken when mem_valid=1 and (any fault flag, or MIE=1 and (mip & mie)!=0); MRET taken when mem_valid=1, mret=1, no fault.
REQ-015 Fault priority, highest first: ebreak (cause 3), illegal_inst (2), ecall (11), load_misaligned (4), store_misaligned (6).
REQ-016 Faults beat interrupts in the same cycle; interrupt priority lowest irq index first; interrupt cause = {1'b1, 31'(16+i)}.
REQ-017 On trap/MRET cycle: redirect=1, all four flushes=1, same cycle (combinational from inputs and state); FSM -> DRAIN.
REQ-018 On trap edge: mepc<=mem_pc, mcause<=cause, mtval<=mem_tval for faults else 0, MPIE<=MIE, MIE<=0.
REQ-019 On MRET edge: MIE<=MPIE, MPIE<=1; redirect_pc=mepc.
REQ-020 Trap target: mtvec base (bits 31:2, low bits zero) for faults; interrupts per REQ-030.
REQ-021 DRAIN: lasts exactly 1 cycle, holds all four flushes=1, redirect=0, no new trap/MRET accepted; -> RUN.
REQ-022 mip[NUM_IRQ-1:0] = irq registered each cycle (1-cycle latency); mip read-only.
REQ-023 CSRs: mstatus 0x300 (MIE bit 3, MPIE bit 7, other bits read 0), mie 0x304, mtvec 0x305, mepc 0x341 (bits 1:0 forced 0), mcause 0x342, mtval 0x343, mip 0x344.
REQ-024 Unmapped csr_addr reads 0, writes ignored.
REQ-025 CSR write coincident with trap/MRET: trap/MRET updates win on conflicting fields; write otherwise applied.
REQ-026 Idle outputs: redirect=0, redirect_pc=0, flushes=0, trap_cause=0.

Reset
REQ-027 nrst low: FSM RUN, mstatus=0, mie=0, mip=0, mepc=0, mcause=0, mtval=0, mtvec=RESET_TVEC, all outputs at REQ-026 values.
REQ-028 Reset mid-DRAIN abandons drain; first cycle after release is RUN with no flush.

Configuration
REQ-029 Macro TRAP_VECTORED_IRQ_EN selects vectored interrupt mode support.
REQ-030 Defined: mtvec[1:0] writable; when mtvec[1:0]=1 interrupt target = base + 4*cause[30:0]; faults always base. Undefined: mtvec[1:0] reads 0, all traps go to base.

Structure
REQ-031 Shared package common_types_pkg holds CSR address constants, cause code constants, FSM state enum.
REQ-032 Sub-module trap_priority: combinational fixed-priority encoder over NUM_IRQ pending bits giving valid + index.

Verification
REQ-033 illegal_inst=1, mem_pc=0x120, mem_tval=0xFFFFFFFF -> same cycle redirect=1, redirect_pc=0x8000, 4 flushes; next cycle mepc=0x120, mcause=2, mtval=0xFFFFFFFF, DRAIN flushes only.
REQ-034 ebreak+ecall+illegal same cycle -> mcause=3.
REQ-035 MIE=1, mie=0x3, irq=0x3, mem_valid=1 -> trap 1 cycle after irq registers, mcause=0x80000010, MIE=0, MPIE=1; irq held during handler -> no retrap.
REQ-036 MRET with mepc=0x124, MPIE=1 -> redirect_pc=0x124, MIE=1 next cycle.
REQ-037 TRAP_VECTORED_IRQ_EN, mtvec=0x8001, irq[2] -> redirect_pc=0x8048; undefined -> mtvec reads 0x8000, redirect_pc=0x8000.
REQ-038 nrst asserted during DRAIN -> flushes drop immediately, CSRs at reset values.
